// File: rtl/hsm_pkg.sv
// Shared types and constants for the GPIO HSM core: the tagged FIFO entry,
// synchronizer depth and the RP strobe classification.
package hsm_pkg;

  localparam int RP_SYNC_STAGES = 2;
  localparam int HSM_DATA_WIDTH = 8;

  typedef struct packed {
    logic                      is_key;
    logic [HSM_DATA_WIDTH-1:0] data;
  } hsm_entry_t;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_KEY,
    CLS_DATA,
    CLS_READ
  } cls_e;

  // Key material is always a write, whatever the direction pin says.
  function automatic cls_e classify(input logic is_key, input logic dir);
    if (is_key)   return CLS_KEY;
    else if (dir) return CLS_DATA;
    else          return CLS_READ;
  endfunction

endpackage

// File: rtl/rp_sync_fifo.sv
// Synchronous circular FIFO of tagged entries with extended-pointer full/empty.
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module rp_sync_fifo
  import hsm_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = hsm_entry_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty,
  output logic   pushed,
  output logic   dropped
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  entry_t      mem [DEPTH];
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign pushed  = push & (~full | do_pop);
  assign dropped = push & ~pushed;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Storage is deliberately left out of reset; only the pointers matter.
  always_ff @(posedge clk) begin
    if (pushed) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (pushed) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/rp_bus_sync.sv
// Raspberry Pi bus front end: synchronizes the async strobe/tag/dir/data pins,
// turns strobe rising edges into FIFO writes or read-request pulses.
module rp_bus_sync
  import hsm_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RP_clock,
  input  logic                  RP_is_key,
  input  logic                  RP_dir,
  input  logic [DATA_WIDTH-1:0] RP_data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_is_key,
  output logic                  rd_req,
  output logic                  overflow,
  output logic [15:0]           rx_count
);

  typedef struct packed {
    logic                  is_key;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [RP_SYNC_STAGES:0]   strobe_sync;
  logic [RP_SYNC_STAGES-1:0] key_sync;
  logic [RP_SYNC_STAGES-1:0] dir_sync;
  logic [DATA_WIDTH-1:0]     data_sync [RP_SYNC_STAGES];
  logic [RP_SYNC_STAGES-1:0] sync_fill;
  logic                      armed;

  logic   strobe_s2;
  logic   strobe_s3;
  logic   strobe_edge;
  cls_e   cls;
  logic   is_write;
  entry_t push_entry;
  entry_t head;
  logic   full;
  logic   empty;
  logic   pushed;
  logic   dropped;

  assign strobe_s2   = strobe_sync[RP_SYNC_STAGES-1];
  assign strobe_s3   = strobe_sync[RP_SYNC_STAGES];
  assign strobe_edge = strobe_s2 & ~strobe_s3 & armed;

  // sync_fill keeps arming off until s2 reflects the pin again after reset,
  // so a strobe held high through reset release cannot fake a rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_sync <= '0;
      key_sync    <= '0;
      dir_sync    <= '0;
      for (int i = 0; i < RP_SYNC_STAGES; i++) data_sync[i] <= '0;
      sync_fill   <= '0;
      armed       <= 1'b0;
    end else begin
      strobe_sync  <= {strobe_sync[RP_SYNC_STAGES-1:0], RP_clock};
      key_sync     <= {key_sync[RP_SYNC_STAGES-2:0], RP_is_key};
      dir_sync     <= {dir_sync[RP_SYNC_STAGES-2:0], RP_dir};
      data_sync[0] <= RP_data_in;
      for (int i = 1; i < RP_SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
      sync_fill    <= {sync_fill[RP_SYNC_STAGES-2:0], 1'b1};
      if (sync_fill[RP_SYNC_STAGES-1] && !strobe_s2) armed <= 1'b1;
    end
  end

  always_comb begin
    cls        = CLS_NONE;
    push_entry = '0;
    if (strobe_edge) cls = classify(key_sync[RP_SYNC_STAGES-1], dir_sync[RP_SYNC_STAGES-1]);
    is_write          = (cls == CLS_KEY) || (cls == CLS_DATA);
    push_entry.is_key = (cls == CLS_KEY);
    push_entry.data   = data_sync[RP_SYNC_STAGES-1];
  end

  rp_sync_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (is_write),
    .push_data (push_entry),
    .pop       (out_valid & out_ready),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .pushed    (pushed),
    .dropped   (dropped)
  );

  assign out_valid  = ~empty;
  assign out_data   = out_valid ? head.data   : '0;
  assign out_is_key = out_valid ? head.is_key : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_req   <= 1'b0;
      overflow <= 1'b0;
      rx_count <= '0;
    end else begin
      rd_req <= (cls == CLS_READ);
      if (dropped) overflow <= 1'b1;
      if (pushed)  rx_count <= rx_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_rp_bus_sync.sv
// Directed bench for rp_bus_sync: a queue-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_rp_bus_sync;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        RP_clock = 1'b0;
  logic        RP_is_key = 1'b0;
  logic        RP_dir = 1'b0;
  logic [7:0]  RP_data_in = 8'h00;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_is_key;
  logic        rd_req;
  logic        overflow;
  logic [15:0] rx_count;

  rp_bus_sync #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .RP_clock   (RP_clock),
    .RP_is_key  (RP_is_key),
    .RP_dir     (RP_dir),
    .RP_data_in (RP_data_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_is_key (out_is_key),
    .rd_req     (rd_req),
    .overflow   (overflow),
    .rx_count   (rx_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    bit         rd;
    logic [8:0] ent;
  } ev_t;

  int          vectors = 0;
  int          errors = 0;
  int          cyc = 0;
  ev_t         evq[$];
  logic [8:0]  mq[$];
  logic [8:0]  got[$];
  logic [8:0]  sent[$];
  bit          m_rd = 0;
  bit          m_ovf = 0;
  logic [15:0] m_rx = '0;
  bit          started = 0;
  int          rd_seen = 0;
  int          rd_edge = -1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: at each edge, a pop happens if the queue held data and ready was high;
  // a scheduled write then lands if there is room, otherwise it is dropped.
  always begin : model
    bit  ready_s, reset_s, pop;
    ev_t ev;
    @(posedge clk);
    ready_s = out_ready;
    reset_s = reset;
    cyc++;
    if (reset_s) begin
      started = 1;
      mq.delete();
      evq.delete();
      m_rd  = 0;
      m_ovf = 0;
      m_rx  = '0;
    end else if (started) begin
      pop  = (mq.size() > 0) && ready_s;
      m_rd = 0;
      if (pop) got.push_back(mq.pop_front());
      if (evq.size() > 0 && evq[0].at == cyc) begin
        ev = evq.pop_front();
        if (ev.rd) m_rd = 1;
        else if (mq.size() < DEPTH) begin
          mq.push_back(ev.ent);
          m_rx++;
        end else m_ovf = 1;
      end
    end
    #1;
    if (started) begin
      checkOutput("out_valid", out_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        checkOutput("out_is_key", out_is_key, mq[0][8]);
        checkOutput("out_data", out_data, mq[0][7:0]);
      end
      checkOutput("rd_req", rd_req, m_rd);
      checkOutput("overflow", overflow, m_ovf);
      checkOutput("rx_count", rx_count, m_rx);
      if (rd_req === 1'b1) begin
        rd_seen++;
        rd_edge = cyc;
      end
    end
  end

  // One full RP transfer; c0 is the edge index at which s1 first sees the strobe.
  task automatic applyStimulus(input bit key, input bit dir, input logic [7:0] data, output int c0);
    @(negedge clk);
    RP_is_key  = key;
    RP_dir     = dir;
    RP_data_in = data;
    repeat (2) @(negedge clk);
    RP_clock = 1'b1;
    c0 = cyc + 1;
    evq.push_back('{at: c0 + 2, rd: (!key && !dir), ent: {key, data}});
    repeat (4) @(negedge clk);
    RP_clock = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset    = 1'b1;
    RP_clock = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    got.delete();
    repeat (6) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((mq.size() != 0 || evq.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    if (n >= 300) begin
      vectors++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d entries left, expected 0", mq.size());
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: got no completion, expected $finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int c0;
    int rd0;
    logic [7:0] d;
    bit k;
    bit done;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    // Key then data with the consumer always ready
    doReset();
    out_ready = 1'b1;
    rd0 = rd_seen;
    applyStimulus(1'b1, 1'b0, 8'hA5, c0);
    applyStimulus(1'b0, 1'b1, 8'h3C, c0);
    drain();
    checkOutput("t1_rx_count", rx_count, 32'd2);
    checkOutput("t1_got_size", got.size(), 32'd2);
    if (got.size() == 2) begin
      checkOutput("t1_first", got[0], 32'h1A5);
      checkOutput("t1_second", got[1], 32'h03C);
    end
    checkOutput("t1_no_rd", rd_seen - rd0, 32'd0);

    // Read strobe
    doReset();
    rd0 = rd_seen;
    applyStimulus(1'b0, 1'b0, 8'hFF, c0);
    drain();
    checkOutput("t2_rd_pulses", rd_seen - rd0, 32'd1);
    checkOutput("t2_rd_edge", rd_edge - c0, 32'd2);
    checkOutput("t2_valid", out_valid, 32'd0);
    checkOutput("t2_rx_count", rx_count, 32'd0);

    // Overflow with the consumer stalled
    doReset();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) applyStimulus(1'b0, 1'b1, 8'(i), c0);
    checkOutput("t3_overflow", overflow, 32'd1);
    checkOutput("t3_rx_count", rx_count, 32'd4);
    out_ready = 1'b1;
    drain();
    checkOutput("t3_got_size", got.size(), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) checkOutput("t3_entry", got[i], 32'(i + 1));

    // Full FIFO with a pop on the edge cycle of the fifth write
    doReset();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 1'b1, 8'(i), c0);
    @(negedge clk);
    RP_is_key  = 1'b0;
    RP_dir     = 1'b1;
    RP_data_in = 8'h05;
    repeat (2) @(negedge clk);
    RP_clock = 1'b1;
    evq.push_back('{at: cyc + 3, rd: 1'b0, ent: 9'h005});
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    RP_clock = 1'b0;
    repeat (4) @(negedge clk);
    drain();
    checkOutput("t4_overflow", overflow, 32'd0);
    checkOutput("t4_rx_count", rx_count, 32'd5);
    checkOutput("t4_got_size", got.size(), 32'd5);
    for (int i = 0; i < 5 && i < got.size(); i++) checkOutput("t4_entry", got[i], 32'(i + 1));

    // Reset while the strobe is held high
    doReset();
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) applyStimulus(1'b0, 1'b1, 8'(8'h10 + i), c0);
    @(negedge clk);
    RP_data_in = 8'h55;
    repeat (2) @(negedge clk);
    RP_clock = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    got.delete();
    checkOutput("t5_valid", out_valid, 32'd0);
    checkOutput("t5_overflow", overflow, 32'd0);
    checkOutput("t5_rx_count", rx_count, 32'd0);
    checkOutput("t5_out_data", out_data, 32'd0);
    repeat (10) @(negedge clk);
    checkOutput("t5_held_no_entry", out_valid, 32'd0);
    RP_clock = 1'b0;
    repeat (4) @(negedge clk);
    out_ready = 1'b1;
    applyStimulus(1'b0, 1'b1, 8'h77, c0);
    drain();
    checkOutput("t5_got_size", got.size(), 32'd1);
    if (got.size() == 1) checkOutput("t5_entry", got[0], 32'h077);
    checkOutput("t5_rx_after", rx_count, 32'd1);

    // Random backpressure over 64 random writes
    doReset();
    sent.delete();
    done = 0;
    fork
      begin
        for (int i = 0; i < 64; i++) begin
          k = 1'($urandom);
          d = 8'($urandom);
          sent.push_back({k, d});
          applyStimulus(k, 1'b1, d, c0);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          out_ready = 1'($urandom);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    checkOutput("t6_got_size", got.size(), 32'd64);
    for (int i = 0; i < 64 && i < got.size(); i++) checkOutput("t6_order", got[i], sent[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
